// File: rtl/key_pkg.sv
// Shared types, HID keycode constants and helpers for the key event path.
package key_pkg;

  // HID usage codes recognised by the game
  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_RIGHT = 8'h4F;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_DOWN  = 8'h51;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_UP    = 8'h52;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_C     = 8'h06;
  localparam logic [7:0] HID_P     = 8'h13;

  localparam int NUM_PULSES = 7;

  typedef enum logic [1:0] {IDLE, DAS, REPEAT} rep_state_t;

  typedef enum logic [2:0] {
    ACT_NONE, ACT_LEFT, ACT_RIGHT, ACT_SDROP,
    ACT_ROT, ACT_HDROP, ACT_HOLD, ACT_PAUSE
  } action_t;

  // Map a raw keycode to its game action; anything unmapped is ACT_NONE.
  function automatic action_t decode_key(input logic [7:0] code);
    case (code)
      HID_A,     HID_LEFT:  return ACT_LEFT;
      HID_D,     HID_RIGHT: return ACT_RIGHT;
      HID_S,     HID_DOWN:  return ACT_SDROP;
      HID_W,     HID_UP:    return ACT_ROT;
      HID_SPACE:            return ACT_HDROP;
      HID_C:                return ACT_HOLD;
      HID_P:                return ACT_PAUSE;
      default:              return ACT_NONE;
    endcase
  endfunction

  // Only horizontal moves and soft drop auto-repeat.
  function automatic logic is_repeatable(input action_t act);
    return (act == ACT_LEFT) || (act == ACT_RIGHT) || (act == ACT_SDROP);
  endfunction

  // One-hot pulse vector; bit order matches the output ports left..pause.
  function automatic logic [NUM_PULSES-1:0] action_onehot(input action_t act);
    case (act)
      ACT_LEFT:  return 7'b000_0001;
      ACT_RIGHT: return 7'b000_0010;
      ACT_SDROP: return 7'b000_0100;
      ACT_ROT:   return 7'b000_1000;
      ACT_HDROP: return 7'b001_0000;
      ACT_HOLD:  return 7'b010_0000;
      ACT_PAUSE: return 7'b100_0000;
      default:   return 7'b000_0000;
    endcase
  endfunction

endpackage

// File: rtl/edge_tick.sv
// Synchroniser plus falling-edge detector: one-cycle tick per falling edge of i_sig.
module edge_tick (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_sig,
  output logic o_tick
);

  logic r_curr;
  logic r_prev;

  // Two-stage capture; idle level of the frame strobe is high, so reset there
  // to avoid a spurious tick straight out of reset.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_curr <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_curr <= i_sig;
      r_prev <= r_curr;
    end
  end

  assign o_tick = r_prev & ~r_curr;

endmodule

// File: rtl/key_event_gen.sv
// Turns the raw HID keycode into one-cycle game action pulses with DAS/ARR
// auto-repeat for left, right and soft drop.
module key_event_gen
  import key_pkg::*;
#(
  parameter int DAS_FRAMES = 10,
  parameter int ARR_FRAMES = 3,
  parameter int CNT_W      = 6
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic       frame_clk,
  input  logic       paused,
  output logic       move_left,
  output logic       move_right,
  output logic       soft_drop,
  output logic       rotate,
  output logic       hard_drop,
  output logic       hold_swap,
  output logic       pause_tgl
);

  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_FRAMES - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_FRAMES - 1);

  logic [7:0]            r_key_q;
  logic [7:0]            r_key_prev;
  rep_state_t            r_state;
  rep_state_t            w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [NUM_PULSES-1:0] r_pulse;
  action_t               w_act_q;
  action_t               w_fire;
  logic [7:0]            w_key_n;
  logic                  w_press;
  logic                  w_tick;

  edge_tick u_frame_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_sig   (frame_clk),
    .o_tick  (w_tick)
  );

  // Unmapped codes collapse to 00 so they behave exactly like a release.
  assign w_act_q   = decode_key(r_key_q);
  assign w_key_n   = (w_act_q == ACT_NONE) ? HID_NONE : r_key_q;
  // r_key_prev doubles as the press latch: a held code never re-fires.
  assign w_press   = (w_act_q != ACT_NONE) && (w_key_n != r_key_prev);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  // Input capture, press latch, FSM state, frame counter and pulse register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_key_q    <= HID_NONE;
      r_key_prev <= HID_NONE;
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_pulse    <= '0;
    end else begin
      r_key_q    <= keycode;
      r_key_prev <= w_key_n;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pulse    <= action_onehot(w_fire);
    end
  end

  // Next-state, counter and action select; a press always beats a tick.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire      = ACT_NONE;
    if (paused) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      if (w_press && (w_act_q == ACT_PAUSE)) w_fire = ACT_PAUSE;
    end else if (w_press) begin
      w_fire      = w_act_q;
      w_cnt_nxt   = '0;
      w_state_nxt = is_repeatable(w_act_q) ? DAS : IDLE;
    end else begin
      unique case (r_state)
        DAS: begin
          if (w_act_q == ACT_NONE) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (w_tick) begin
            if (r_cnt == DAS_LAST) begin
              w_fire      = w_act_q;
              w_cnt_nxt   = '0;
              w_state_nxt = REPEAT;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end
        REPEAT: begin
          if (w_act_q == ACT_NONE) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (w_tick) begin
            if (r_cnt == ARR_LAST) begin
              w_fire    = w_act_q;
              w_cnt_nxt = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign move_left  = r_pulse[0];
  assign move_right = r_pulse[1];
  assign soft_drop  = r_pulse[2];
  assign rotate     = r_pulse[3];
  assign hard_drop  = r_pulse[4];
  assign hold_swap  = r_pulse[5];
  assign pause_tgl  = r_pulse[6];

endmodule

// File: tb/tb_key_event_gen.sv
// Scoreboard bench for key_event_gen: stimulus pushes expected pulses with
// their expected cycle; a negedge monitor pops and compares every pulse seen.
module tb_key_event_gen;
  import key_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] keycode = 8'h04;
  logic       frame_clk = 1'b1;
  logic       paused = 1'b0;
  logic       move_left, move_right, soft_drop, rotate, hard_drop, hold_swap, pause_tgl;

  typedef struct {
    action_t act;
    int      cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  key_event_gen #(.DAS_FRAMES(10), .ARR_FRAMES(3), .CNT_W(6)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .keycode    (keycode),
    .frame_clk  (frame_clk),
    .paused     (paused),
    .move_left  (move_left),
    .move_right (move_right),
    .soft_drop  (soft_drop),
    .rotate     (rotate),
    .hard_drop  (hard_drop),
    .hold_swap  (hold_swap),
    .pause_tgl  (pause_tgl)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input action_t act, input int c);
    exp_t e;
    e.act = act;
    e.cyc = c;
    sb_q.push_back(e);
  endtask

  // Change keycode on a negedge; a press shows up 2 posedges later.
  task automatic set_key(input logic [7:0] k, input action_t exp_act);
    @(negedge Clk);
    keycode = k;
    if (exp_act != ACT_NONE) expect_at(exp_act, cyc + 2);
  endtask

  // One frame: falling edge of frame_clk, the tick it produces lands 2 posedges later.
  task automatic tick_frame(input action_t exp_act);
    @(negedge Clk);
    frame_clk = 1'b0;
    if (exp_act != ACT_NONE) expect_at(exp_act, cyc + 2);
    repeat (3) @(negedge Clk);
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  // Hand schedule for DAS=10, ARR=3: repeats at ticks 10, 13, 16, 19, ...
  function automatic bit rep_due(input int i);
    return (i == 10) || ((i > 10) && ((i - 10) % 3 == 0));
  endfunction

  task automatic hold_frames(input int n, input action_t rep_act);
    for (int i = 1; i <= n; i++)
      tick_frame((rep_act != ACT_NONE && rep_due(i)) ? rep_act : ACT_NONE);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Monitor: every cycle with any pulse must match the head of the scoreboard.
  always @(negedge Clk) begin
    logic [6:0] v;
    action_t    got;
    exp_t       e;
    v = {pause_tgl, hold_swap, hard_drop, rotate, soft_drop, move_right, move_left};
    if (Reset_n && (v != 7'd0)) begin
      check("onehot", 32'($countones(v)), 32'd1);
      if      (v[0]) got = ACT_LEFT;
      else if (v[1]) got = ACT_RIGHT;
      else if (v[2]) got = ACT_SDROP;
      else if (v[3]) got = ACT_ROT;
      else if (v[4]) got = ACT_HDROP;
      else if (v[5]) got = ACT_HOLD;
      else           got = ACT_PAUSE;
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 32'(got), 32'(ACT_NONE));
      end else begin
        e = sb_q.pop_front();
        check("pulse_act", 32'(got), 32'(e.act));
        check("pulse_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1 Reset with 04 held: quiet outputs, then one move_left after release
    idle(3);
    check("reset_outputs",
          32'({pause_tgl, hold_swap, hard_drop, rotate, soft_drop, move_right, move_left}), 32'd0);
    Reset_n = 1'b1;
    expect_at(ACT_LEFT, cyc + 2);
    idle(8);
    set_key(8'h00, ACT_NONE);
    idle(5);

    // 2 Tap rotate held 5 frames: one pulse only
    set_key(8'h1A, ACT_ROT);
    hold_frames(5, ACT_NONE);
    set_key(8'h00, ACT_NONE);
    idle(5);

    // 3 DAS/ARR: right held 20 frames -> press + ticks 10, 13, 16, 19
    set_key(8'h07, ACT_RIGHT);
    hold_frames(20, ACT_RIGHT);
    set_key(8'h00, ACT_NONE);
    idle(5);

    // 4 Direct switch left -> right restarts DAS
    set_key(8'h04, ACT_LEFT);
    hold_frames(12, ACT_LEFT);
    set_key(8'h07, ACT_RIGHT);
    hold_frames(10, ACT_RIGHT);
    set_key(8'h00, ACT_NONE);
    idle(5);

    // 5 Pause: only pause_tgl fires; unpausing with 51 held fires nothing
    @(negedge Clk);
    paused = 1'b1;
    set_key(8'h2C, ACT_NONE);
    idle(5);
    set_key(8'h13, ACT_PAUSE);
    idle(5);
    set_key(8'h51, ACT_NONE);
    hold_frames(2, ACT_NONE);
    @(negedge Clk);
    paused = 1'b0;
    hold_frames(3, ACT_NONE);
    set_key(8'h00, ACT_NONE);
    idle(5);
    set_key(8'h51, ACT_SDROP);
    idle(5);
    set_key(8'h00, ACT_NONE);
    idle(5);

    // 6 Press in the same cycle as a tick: one soft_drop, tick ignored
    @(negedge Clk);
    keycode   = 8'h16;
    frame_clk = 1'b0;
    expect_at(ACT_SDROP, cyc + 2);
    idle(3);
    frame_clk = 1'b1;
    idle(4);
    hold_frames(3, ACT_NONE);
    set_key(8'h00, ACT_NONE);
    idle(5);
    // Unmapped code produces nothing
    set_key(8'h3A, ACT_NONE);
    hold_frames(3, ACT_NONE);
    set_key(8'h00, ACT_NONE);
    idle(10);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
